ddi_pkt_tx: RTL and testbench

- Transmit end of the DDI image link.
- Latches one pixel packet (8-bit Header + 24-bit ImageData) on a strobe, computes an 8-bit CheckSum, and serialises 5 bytes over one UART 8N1 line: Header, ImageData[23:16], ImageData[15:8], ImageData[7:0], CheckSum.
- Drives the rx pin of the packet receiver (uart_rx), which rebuilds Header/ImageData/CheckSum and asserts Strb/DataRdy.

---
 rtl/ddi_pkt_tx.sv | 169 ++++++++++++++++
 tb/tb_ddi_pkt_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ddi_pkt_tx.sv
`timescale 1ns/1ps
// DDI image-link transmitter: latches one pixel packet (header + 24-bit pixel), registers its
// 8-bit additive checksum, and sends the five bytes back-to-back on a UART 8N1 line.
module ddi_pkt_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Strb,
  input  logic [7:0]  Header,
  input  logic [23:0] ImageData,
  output logic        busy,
  output logic        done,
  output logic [7:0]  CheckSum,
  output logic        tx
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic StopMax = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      byte_q, byte_d;
  logic            stop_q, stop_d;
  logic [31:0]     shadow_q, shadow_d;
  logic [7:0]      csum_q, csum_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic       accept;
  logic       bit_end;
  logic [2:0] bit_nxt;
  logic [7:0] sum;
  logic [7:0] cur_byte;

  assign accept  = Strb && !busy_q;
  assign bit_end = (cnt_q == CntMax);
  assign bit_nxt = bit_q + 3'd1;
  // Carries discarded: 8-bit result of an 8-bit sum.
  assign sum     = Header + ImageData[23:16] + ImageData[15:8] + ImageData[7:0];

  // Select the byte currently on the wire from the latched packet.
  always_comb begin
    cur_byte = csum_q;
    case (byte_q)
      3'd0:    cur_byte = shadow_q[31:24];
      3'd1:    cur_byte = shadow_q[23:16];
      3'd2:    cur_byte = shadow_q[15:8];
      3'd3:    cur_byte = shadow_q[7:0];
      default: cur_byte = csum_q;
    endcase
  end

  // Next-state logic; tx/busy/done are computed here so they leave the block registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + CntW'(1);
    bit_d    = bit_q;
    byte_d   = byte_q;
    stop_d   = stop_q;
    shadow_d = shadow_q;
    csum_d   = csum_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        if (accept) begin
          shadow_d = {Header, ImageData};
          csum_d   = sum;
          state_d  = StStart;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          byte_d   = 3'd0;
          bit_d    = 3'd0;
          stop_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopMax) begin
            if (byte_q == 3'd4) begin
              state_d = StDone;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              tx_d    = 1'b1;
            end else begin
              // Next byte starts immediately: no idle between bytes of a packet.
              byte_d  = byte_q + 3'd1;
              state_d = StStart;
              tx_d    = 1'b0;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset; reset wins over a simultaneous strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 3'd0;
      stop_q   <= 1'b0;
      shadow_q <= 32'd0;
      csum_q   <= 8'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      stop_q   <= stop_d;
      shadow_q <= shadow_d;
      csum_q   <= csum_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign CheckSum = csum_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_ddi_pkt_tx.sv
`timescale 1ns/1ps
// Directed bench for ddi_pkt_tx at CLKS_PER_BIT=4: mid-bit UART decoding of captured tx samples,
// frame timing, busy rejection, back-to-back and mid-packet reset.
module tb_ddi_pkt_tx;

  localparam int Cpb = 4;
  localparam int F   = 5 * 10 * Cpb;

  logic        clk = 1'b0;
  logic        rst;
  logic        strb;
  logic [7:0]  header;
  logic [23:0] image_data;
  logic        busy;
  logic        done;
  logic [7:0]  check_sum;
  logic        tx;

  int n_checks = 0;
  int n_errors = 0;
  int n_wait;
  logic busy_seen;
  logic tx_log [F];

  always #5 clk = ~clk;

  ddi_pkt_tx #(
    .CLKS_PER_BIT(Cpb),
    .STOP_BITS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .Strb     (strb),
    .Header   (header),
    .ImageData(image_data),
    .busy     (busy),
    .done     (done),
    .CheckSum (check_sum),
    .tx       (tx)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until done is seen, bounded; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  // Send one packet, capture tx for the full frame, optionally poke Strb/inputs mid-frame.
  task automatic run_frame(input string tag, input logic [7:0] hdr, input logic [23:0] img,
                           input logic [7:0] exp_sum, input int poke_at);
    logic        busy_all;
    logic        done_any;
    logic [39:0] exp_bytes;
    check({tag, "_idle_before"}, busy, 1'b0);
    header     = hdr;
    image_data = img;
    strb       = 1'b1;
    tick();
    strb = 1'b0;
    check({tag, "_csum"}, check_sum, exp_sum);
    check({tag, "_busy_rise"}, busy, 1'b1);
    check({tag, "_start_tx"}, tx, 1'b0);
    busy_all = 1'b1;
    done_any = 1'b0;
    for (int i = 0; i < F; i++) begin
      tx_log[i] = tx;
      busy_all &= busy;
      done_any |= done;
      if (i == poke_at) begin
        strb       = 1'b1;
        header     = 8'h11;
        image_data = 24'h000000;
      end else if (i == poke_at + 1) begin
        strb = 1'b0;
      end
      tick();
    end
    check({tag, "_busy_held"}, busy_all, 1'b1);
    check({tag, "_no_early_done"}, done_any, 1'b0);
    check({tag, "_done_at_F"}, done, 1'b1);
    check({tag, "_busy_fall"}, busy, 1'b0);
    check({tag, "_tx_done"}, tx, 1'b1);
    check({tag, "_csum_hold"}, check_sum, exp_sum);
    exp_bytes = {hdr, img, exp_sum};
    for (int b = 0; b < 5; b++) begin
      logic [7:0] v;
      int base;
      base = b * 10 * Cpb + Cpb / 2;
      for (int j = 0; j < 8; j++) v[j] = tx_log[base + (1 + j) * Cpb];
      check($sformatf("%s_start%0d", tag, b), tx_log[base], 1'b0);
      check($sformatf("%s_byte%0d", tag, b), v, exp_bytes[39 - 8 * b -: 8]);
      check($sformatf("%s_stop%0d", tag, b), tx_log[base + 9 * Cpb], 1'b1);
    end
    tick();
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    // Reset with Strb asserted: nothing accepted.
    rst        = 1'b1;
    strb       = 1'b1;
    header     = 8'hA5;
    image_data = 24'h123456;
    repeat (3) begin
      tick();
      check("rst_tx", tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_csum", check_sum, 8'h00);
    end
    rst  = 1'b0;
    strb = 1'b0;
    tick();
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_tx", tx, 1'b1);

    run_frame("basic", 8'hA5, 24'h123456, 8'h41, -1);
    run_frame("wrap", 8'hFF, 24'hFFFFFF, 8'hFC, -1);
    run_frame("busy_rej", 8'h5A, 24'hABCDEF, 8'hC1, 50);
    busy_seen = 1'b0;
    repeat (250) begin
      busy_seen |= busy;
      tick();
    end
    check("no_second_pkt", busy_seen, 1'b0);

    // Back-to-back with Strb held high.
    header     = 8'hA5;
    image_data = 24'h123456;
    strb       = 1'b1;
    tick();
    check("b2b_busy", busy, 1'b1);
    wait_done(n_wait);
    check("b2b_first_done", n_wait, 200);
    check("b2b_gap_tx", tx, 1'b1);
    check("b2b_gap_busy", busy, 1'b0);
    tick();
    check("b2b_restart_tx", tx, 1'b0);
    check("b2b_restart_busy", busy, 1'b1);
    wait_done(n_wait);
    check("b2b_period", n_wait + 1, 201);
    check("b2b_gap2_tx", tx, 1'b1);
    tick();
    strb = 1'b0;
    check("b2b_restart2_tx", tx, 1'b0);
    wait_done(n_wait);
    check("b2b_period2", n_wait + 1, 201);
    tick();
    check("b2b_stopped", busy, 1'b0);

    // Reset in the middle of a packet.
    header     = 8'h77;
    image_data = 24'h0055AA;
    strb       = 1'b1;
    tick();
    strb = 1'b0;
    repeat (89) tick();
    check("mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_csum", check_sum, 8'h00);
    tick();
    check("mid_rst_idle", busy, 1'b0);
    run_frame("after_rst", 8'h3C, 24'h000001, 8'h3D, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
